// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in / parallel-out deserializer.
package sipo_pkg;

   // Assembly state: IDLE holds no bits, SHIFT holds 1..WIDTH-1 bits.
   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } sipo_state_e;

   // Legal range for the parallel word width.
   localparam int unsigned WIDTH_MIN = 2;
   localparam int unsigned WIDTH_MAX = 32;

endpackage : sipo_pkg

// File: rtl/sipo_deserializer.sv
// Serial-in / parallel-out deserializer with a one-word holding register,
// valid/ready output handshake, frame resynchronisation and overrun flag.
module sipo_deserializer
   import sipo_pkg::*;
#(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ser_in,
   input  logic             ser_valid,
   input  logic             frame_start,
   output logic [WIDTH-1:0] par_out,
   output logic             par_valid,
   input  logic             par_ready,
   output logic             busy,
   output logic             overrun
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

   // Reject illegal widths at elaboration time.
   if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
      $error("sipo_deserializer: WIDTH out of range");
   end

   sipo_state_e      state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] par_out_q, par_out_d;
   logic             par_valid_q, par_valid_d;
   logic             overrun_q, overrun_d;
   logic             word_done;
   logic             load_word;
   logic             drop_word;

   // Insert one serial bit; the first bit of a word migrates to the
   // configured end of the word after WIDTH insertions.
   function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                 input logic             bit_in);
      if (MSB_FIRST != 0)
         return {cur[WIDTH-2:0], bit_in};
      else
         return {bit_in, cur[WIDTH-1:1]};
   endfunction

   // Next-state, counter, shift register and holding-register logic.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      shift_d     = shift_q;
      word_done   = 1'b0;
      load_word   = 1'b0;
      drop_word   = 1'b0;
      par_out_d   = par_out_q;
      par_valid_d = par_valid_q;
      overrun_d   = 1'b0;

      if (frame_start) begin
         // Resync discards partial bits; a coincident bit starts a new word.
         count_d = '0;
         shift_d = '0;
         state_d = IDLE;
         if (ser_valid) begin
            shift_d = shift_in('0, ser_in);
            count_d = CW'(1);
            state_d = SHIFT;
         end
      end else if (ser_valid) begin
         shift_d = shift_in(shift_q, ser_in);
         if (count_q == LAST_IDX) begin
            word_done = 1'b1;
            count_d   = '0;
            state_d   = IDLE;
         end else begin
            count_d = count_q + CW'(1);
            state_d = SHIFT;
         end
      end

      // Holding register: a completed word loads only if the slot is free
      // or being consumed this cycle; otherwise it is dropped.
      load_word = word_done && (!par_valid_q || par_ready);
      drop_word = word_done && par_valid_q && !par_ready;

      if (load_word) begin
         par_out_d   = shift_d;
         par_valid_d = 1'b1;
      end else if (par_valid_q && par_ready) begin
         par_valid_d = 1'b0;
      end

      overrun_d = drop_word;
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath registers: bit counter, shift register, output holding stage.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q     <= '0;
         shift_q     <= '0;
         par_out_q   <= '0;
         par_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         count_q     <= count_d;
         shift_q     <= shift_d;
         par_out_q   <= par_out_d;
         par_valid_q <= par_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   // Output mapping.
   always_comb begin
      par_out   = par_out_q;
      par_valid = par_valid_q;
      overrun   = overrun_q;
      busy      = (state_q == SHIFT);
   end

endmodule : sipo_deserializer

// File: tb/tb_sipo_deserializer.sv
// Directed self-checking bench: one MSB-first and one LSB-first instance
// driven by the same stimulus, WIDTH=4.
module tb_sipo_deserializer;

   localparam int unsigned W = 4;

   logic         clk;
   logic         rst;
   logic         ser_in;
   logic         ser_valid;
   logic         frame_start;
   logic         par_ready;
   logic [W-1:0] msb_par_out, lsb_par_out;
   logic         msb_par_valid, lsb_par_valid;
   logic         msb_busy, lsb_busy;
   logic         msb_overrun, lsb_overrun;

   int checks = 0;
   int errors = 0;

   sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1)) dut_msb (
      .clk         (clk),
      .rst         (rst),
      .ser_in      (ser_in),
      .ser_valid   (ser_valid),
      .frame_start (frame_start),
      .par_out     (msb_par_out),
      .par_valid   (msb_par_valid),
      .par_ready   (par_ready),
      .busy        (msb_busy),
      .overrun     (msb_overrun)
   );

   sipo_deserializer #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
      .clk         (clk),
      .rst         (rst),
      .ser_in      (ser_in),
      .ser_valid   (ser_valid),
      .frame_start (frame_start),
      .par_out     (lsb_par_out),
      .par_valid   (lsb_par_valid),
      .par_ready   (par_ready),
      .busy        (lsb_busy),
      .overrun     (lsb_overrun)
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Apply inputs for one cycle; returns 1 ns after the sampling edge.
   task automatic tick(input logic v, input logic b, input logic fs, input logic rdy);
      ser_valid   = v;
      ser_in      = b;
      frame_start = fs;
      par_ready   = rdy;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; ser_in = 1'b0; ser_valid = 1'b0; frame_start = 1'b0; par_ready = 1'b0;
      #2;
      check("rst_par_out", 32'(msb_par_out), 32'h0);
      check("rst_par_valid", 32'(msb_par_valid), 32'h0);
      check("rst_busy", 32'(msb_busy), 32'h0);
      check("rst_overrun", 32'(msb_overrun), 32'h0);
      check("rst_lsb_busy", 32'(lsb_busy), 32'h0);
      @(posedge clk); #1;
      @(posedge clk); #3;
      rst = 1'b1;
      check("rel_par_valid", 32'(msb_par_valid), 32'h0);

      // Basic word 1,0,1,0 with consumer ready.
      tick(1, 1, 0, 1);
      check("t1_busy_b1", 32'(msb_busy), 32'h1);
      check("t1_valid_b1", 32'(msb_par_valid), 32'h0);
      tick(1, 0, 0, 1);
      tick(1, 1, 0, 1);
      check("t1_valid_b3", 32'(msb_par_valid), 32'h0);
      tick(1, 0, 0, 1);
      check("t1_msb_word", 32'(msb_par_out), 32'ha);
      check("t1_lsb_word", 32'(lsb_par_out), 32'h5);
      check("t1_valid", 32'(msb_par_valid), 32'h1);
      check("t1_busy_done", 32'(msb_busy), 32'h0);
      tick(0, 0, 0, 1);
      check("t1_valid_clr", 32'(msb_par_valid), 32'h0);

      // Overrun: 1010 then 1100 with consumer stalled.
      tick(1, 1, 0, 0); tick(1, 0, 0, 0); tick(1, 1, 0, 0); tick(1, 0, 0, 0);
      check("t2_word1", 32'(msb_par_out), 32'ha);
      check("t2_valid1", 32'(msb_par_valid), 32'h1);
      check("t2_ovr_none", 32'(msb_overrun), 32'h0);
      tick(1, 1, 0, 0); tick(1, 1, 0, 0); tick(1, 0, 0, 0);
      check("t2_ovr_early", 32'(msb_overrun), 32'h0);
      tick(1, 0, 0, 0);
      check("t2_ovr_pulse", 32'(msb_overrun), 32'h1);
      check("t2_kept", 32'(msb_par_out), 32'ha);
      check("t2_lsb_kept", 32'(lsb_par_out), 32'h5);
      check("t2_busy", 32'(msb_busy), 32'h0);
      tick(0, 0, 0, 0);
      check("t2_ovr_end", 32'(msb_overrun), 32'h0);
      check("t2_stable", 32'(msb_par_out), 32'ha);
      tick(0, 0, 0, 1);
      check("t2_xfer", 32'(msb_par_valid), 32'h0);
      tick(0, 0, 0, 1);
      check("t2_single", 32'(msb_par_valid), 32'h0);

      // frame_start without ser_valid drops back to IDLE.
      tick(1, 1, 0, 1);
      tick(0, 0, 1, 1);
      check("t3_fs_idle", 32'(msb_busy), 32'h0);

      // Resync with coincident bit: 1,1 | fs+0,1,1,0 -> 0110.
      tick(1, 1, 0, 1);
      check("t3_busy1", 32'(msb_busy), 32'h1);
      tick(1, 1, 0, 1);
      check("t3_busy2", 32'(msb_busy), 32'h1);
      tick(1, 0, 1, 1);
      check("t3_busy_fs", 32'(msb_busy), 32'h1);
      tick(1, 1, 0, 1);
      check("t3_busy4", 32'(msb_busy), 32'h1);
      tick(1, 1, 0, 1);
      check("t3_busy5", 32'(msb_busy), 32'h1);
      check("t3_no_word", 32'(msb_par_valid), 32'h0);
      tick(1, 0, 0, 1);
      check("t3_word", 32'(msb_par_out), 32'h6);
      check("t3_valid", 32'(msb_par_valid), 32'h1);

      // frame_start leaves a pending word alone.
      tick(0, 0, 1, 0);
      check("t3_fs_keep_valid", 32'(msb_par_valid), 32'h1);
      check("t3_fs_keep_word", 32'(msb_par_out), 32'h6);

      // Reset mid-word, then 0,0,1,1 -> 0011.
      tick(1, 1, 0, 1);
      tick(1, 1, 0, 1);
      check("t4_busy_pre", 32'(msb_busy), 32'h1);
      #2 rst = 1'b0;
      #1;
      check("t4_async_busy", 32'(msb_busy), 32'h0);
      check("t4_async_word", 32'(msb_par_out), 32'h0);
      check("t4_async_valid", 32'(msb_par_valid), 32'h0);
      @(posedge clk); #2;
      rst = 1'b1;
      tick(1, 0, 0, 1); tick(1, 0, 0, 1); tick(1, 1, 0, 1);
      check("t4_no_partial", 32'(msb_par_valid), 32'h0);
      tick(1, 1, 0, 1);
      check("t4_word", 32'(msb_par_out), 32'h3);
      check("t4_valid", 32'(msb_par_valid), 32'h1);
      tick(0, 0, 0, 1);

      // Gapped bits 1,0,1,0 then 0110 completing on the accepting cycle.
      tick(1, 1, 0, 0);
      tick(1, 0, 0, 0);
      tick(0, 0, 0, 0);
      tick(1, 1, 0, 0);
      tick(0, 0, 0, 0); tick(0, 0, 0, 0);
      check("t5_busy_gap", 32'(msb_busy), 32'h1);
      tick(1, 0, 0, 0);
      for (int i = 0; i < 3; i++) tick(0, 0, 0, 0);
      check("t5_word1", 32'(msb_par_out), 32'ha);
      check("t5_lsb_word1", 32'(lsb_par_out), 32'h5);
      check("t5_valid1", 32'(msb_par_valid), 32'h1);
      tick(1, 0, 0, 0); tick(1, 1, 0, 0); tick(1, 1, 0, 0);
      tick(1, 0, 0, 1);
      check("t5_word2", 32'(msb_par_out), 32'h6);
      check("t5_valid2", 32'(msb_par_valid), 32'h1);
      check("t5_no_ovr", 32'(msb_overrun), 32'h0);
      tick(0, 0, 0, 0);
      check("t5_no_ovr2", 32'(msb_overrun), 32'h0);
      check("t5_hold", 32'(msb_par_out), 32'h6);
      tick(0, 0, 0, 1);
      check("t5_drain", 32'(msb_par_valid), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_sipo_deserializer

// File: doc/sipo_deserializer.md
SIPO_DESERIALIZER -- requirements
Module: sipo_deserializer

Interface
REQ-001 Parameter WIDTH, default 4: parallel word width in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = first serial bit lands in par_out[WIDTH-1]; 0 = first bit lands in par_out[0].
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 ser_in  input  1  serial data bit.
REQ-006 ser_valid  input  1  ser_in is sampled on this clock edge.
REQ-007 frame_start  input  1  resynchronisation: discards any partial word.
REQ-008 par_out  output  WIDTH  assembled parallel word.
REQ-009 par_valid  output  1  par_out holds an unconsumed word.
REQ-010 par_ready  input  1  consumer accepts par_out this cycle.
REQ-011 busy  output  1  partial word in progress (state SHIFT).
REQ-012 overrun  output  1  one-cycle pulse: a completed word was dropped.

Function
REQ-013 State machine, two states: IDLE (bit count 0) and SHIFT (1..WIDTH-1 bits held).
REQ-014 IDLE -> SHIFT on ser_valid; SHIFT -> IDLE when the WIDTH-th bit is sampled or on frame_start without ser_valid; otherwise hold state.
REQ-015 Each ser_valid cycle shifts ser_in into the internal shift register and increments the bit counter; cycles without ser_valid change nothing (gaps allowed, unbounded).
REQ-016 When the WIDTH-th bit is sampled, the complete word is transferred to the par_out holding register and the counter returns to 0; par_out and par_valid update on that same edge, so they are visible one cycle after the final bit is presented.
REQ-017 Handshake: a transfer occurs on a cycle with par_valid=1 and par_ready=1; par_valid then clears unless a new word completes on the same edge.
REQ-018 Word completes, par_valid=1 and par_ready=1 on the same cycle: new word loads, par_valid stays 1, no overrun.
REQ-019 Word completes, par_valid=1 and par_ready=0: new word is dropped, par_out is unchanged, overrun pulses high for exactly one cycle, and the counter still returns to 0.
REQ-020 par_out shall remain stable while par_valid=1 and no transfer occurs.
REQ-021 frame_start clears the counter and discards partial bits; with ser_valid in the same cycle, that bit becomes bit 1 of a new word (state SHIFT, count 1).
REQ-022 frame_start does not affect par_out, par_valid or a pending handshake.
REQ-023 busy=1 exactly when state is SHIFT.
REQ-024 The bit counter width is $clog2(WIDTH)+1 bits and shall never exceed WIDTH-1 at rest.

Reset
REQ-025 rst low asynchronously forces state IDLE, counter 0, shift register 0, par_out 0, par_valid 0, busy 0, overrun 0.
REQ-026 Reset mid-word discards all partial bits; the first ser_valid after release is bit 1 of a new word.
REQ-027 Outputs leave reset values only on the first rising clk edge after rst deasserts.

Structure
REQ-028 Shared package sipo_pkg holds the state enumeration (IDLE, SHIFT) and the WIDTH legality bounds.
REQ-029 Single module, no sub-modules; the shift register, counter, holding register and FSM are all in sipo_deserializer.

Verification (WIDTH=4)
REQ-030 MSB_FIRST=1, bits 1,0,1,0 on 4 consecutive ser_valid cycles, par_ready=1 -> par_out=4'b1010, par_valid=1 for one cycle, starting the cycle after the 4th bit.
REQ-031 MSB_FIRST=0, same stimulus -> par_out=4'b0101.
REQ-032 par_ready=0, send 1010 then 1100 -> par_out stays 1010, overrun pulses once at completion of 1100; raising par_ready then yields a single transfer of 1010.
REQ-033 Send 1,1 then frame_start with ser_valid (ser_in=0), then 1,1,0 -> par_out=4'b0110; busy=1 throughout.
REQ-034 Assert rst after 2 bits, release, send 0,0,1,1 -> par_out=4'b0011; no output appears from the partial bits.
REQ-035 Send 1010 with idle gaps of 0..3 cycles between bits, then complete 0110 on a cycle where the consumer accepts 1010 -> par_valid stays 1, par_out=4'b0110, no overrun.
